// File: rtl/ccd_frame_timer_pkg.sv
// Shared CCD timing types and frame-period arithmetic.
package ccd_timing_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_XFER    = 3'd1,
    S_GUARD   = 3'd2,
    S_READOUT = 3'd3,
    S_HOLD    = 3'd4
  } ccd_state_e;

  // Shortest frame that still fits shift pulse, guard and full readout.
  function automatic int unsigned t_min(input int unsigned pl, input int unsigned g,
                                        input int unsigned n, input int unsigned pd);
    return pl + g + n * pd;
  endfunction

  // Requested period, saturated to the counter range instead of wrapping.
  function automatic logic [63:0] sat_req(input logic [63:0] base, input logic [63:0] step,
                                          input logic [63:0] fsel, input int cnt_w);
    logic [63:0] req;
    logic [63:0] lim;
    req = base + fsel * step;
    lim = (64'd1 << cnt_w) - 64'd1;
    return (req > lim) ? lim : req;
  endfunction

endpackage

// File: rtl/ccd_frame_timer_if.sv
// Control and pad/ADC signal bundle of the CCD frame timer.
interface ccd_frame_timer_if #(
  parameter int FSEL_W = 8,
  parameter int PIX_W  = 12
);
  logic              enable;
  logic              single_shot;
  logic              start;
  logic [FSEL_W-1:0] f_select;
  logic              phi_p;
  logic              phi_l1;
  logic              phi_l2;
  logic              phi_r;
  logic              sample;
  logic [PIX_W-1:0]  pix_idx;
  logic              frame_done;
  logic              busy;
  logic              exp_clamped;

  modport master (
    output enable, single_shot, start, f_select,
    input  phi_p, phi_l1, phi_l2, phi_r, sample, pix_idx, frame_done, busy, exp_clamped
  );

  modport slave (
    input  enable, single_shot, start, f_select,
    output phi_p, phi_l1, phi_l2, phi_r, sample, pix_idx, frame_done, busy, exp_clamped
  );
endinterface

// File: rtl/ccd_pixel_phase.sv
// Pixel phase/index counters and registered transfer, reset-gate and sample strobes.
module ccd_pixel_phase #(
  parameter int PIX_DIV  = 8,
  parameter int N_PIXELS = 3694,
  parameter int PIX_W    = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_i,
  output logic             phi_l1_o,
  output logic             phi_l2_o,
  output logic             phi_r_o,
  output logic             sample_o,
  output logic [PIX_W-1:0] pix_idx_o,
  output logic             last_pixel_o
);
  localparam int PH_W = $clog2(PIX_DIV);

  logic [PH_W-1:0]  ph_q, ph_d;
  logic [PIX_W-1:0] px_q, px_d;
  logic             wrap;

  assign wrap         = (ph_q == PH_W'(PIX_DIV - 1));
  assign last_pixel_o = run_i && wrap && (px_q == PIX_W'(N_PIXELS - 1));

  always_comb begin
    ph_d = wrap ? '0 : ph_q + 1'b1;
    px_d = px_q;
    if (wrap) px_d = last_pixel_o ? '0 : px_q + 1'b1;
    // Counters park at zero so each readout starts on pixel 0, phase 0.
    if (!run_i) begin
      ph_d = '0;
      px_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q      <= '0;
      px_q      <= '0;
      phi_l1_o  <= 1'b0;
      phi_l2_o  <= 1'b0;
      phi_r_o   <= 1'b0;
      sample_o  <= 1'b0;
      pix_idx_o <= '0;
    end else begin
      ph_q      <= ph_d;
      px_q      <= px_d;
      phi_l2_o  <= run_i && (ph_q < PH_W'(PIX_DIV / 2));
      phi_l1_o  <= run_i && !(ph_q < PH_W'(PIX_DIV / 2));
      phi_r_o   <= run_i && (ph_q < PH_W'(PIX_DIV / 4));
      sample_o  <= run_i && (ph_q == PH_W'(3 * PIX_DIV / 4));
      pix_idx_o <= run_i ? px_q : '0;
    end
  end
endmodule

// File: rtl/ccd_frame_timer.sv
// CCD frame sequencer: shift pulse, guard, pixel readout and hold up to the exposure period.
module ccd_frame_timer
  import ccd_timing_pkg::*;
#(
  parameter int          CNT_W     = 32,
  parameter int          FSEL_W    = 8,
  parameter int unsigned MIN_EXP   = 32'h186A00,
  parameter int unsigned EXP_STEP  = 32'h6429,
  parameter int unsigned N_PIXELS  = 3694,
  parameter int unsigned PIX_DIV   = 8,
  parameter int unsigned PULSE_LEN = 8,
  parameter int unsigned GUARD     = 4
) (
  input logic          clk,
  input logic          rst,
  ccd_frame_timer_if.slave bus
);
  localparam int unsigned TMIN  = t_min(PULSE_LEN, GUARD, N_PIXELS, PIX_DIV);
  localparam int          PIX_W = (N_PIXELS > 1) ? $clog2(N_PIXELS) : 1;

  ccd_state_e       state_q, state_d;
  logic [CNT_W-1:0] fc_q, fc_d, t_q, t_d;
  logic             clamp_q, clamp_d;
  logic             phi_p_q, busy_q, done_q, expc_q;
  logic [FSEL_W-1:0] fsel;
  logic [63:0]      treq, tfrm;
  logic             run, last_pix, eof, restart;

  assign fsel = bus.f_select;
  assign treq = sat_req(64'(MIN_EXP), 64'(EXP_STEP), 64'(fsel), CNT_W);
  assign tfrm = (treq < 64'(TMIN)) ? 64'(TMIN) : treq;
  assign run  = (state_q == S_READOUT);
  assign eof  = ((run && last_pix) || state_q == S_HOLD) && (fc_q == t_q - CNT_W'(1));

  always_comb begin
    state_d = state_q;
    fc_d    = fc_q + CNT_W'(1);
    t_d     = t_q;
    clamp_d = clamp_q;
    restart = 1'b0;
    case (state_q)
      S_IDLE: begin
        fc_d    = '0;
        restart = bus.enable && (!bus.single_shot || bus.start);
      end
      S_XFER:    if (fc_q == CNT_W'(PULSE_LEN - 1)) state_d = S_GUARD;
      S_GUARD:   if (fc_q == CNT_W'(PULSE_LEN + GUARD - 1)) state_d = S_READOUT;
      S_READOUT: if (last_pix) state_d = S_HOLD;
      S_HOLD:    ;
      default:   state_d = S_IDLE;
    endcase
    // End of frame: a minimum-length frame ends straight from READOUT.
    if (eof) begin
      fc_d = '0;
      if (bus.enable && !bus.single_shot) restart = 1'b1;
      else state_d = S_IDLE;
    end
    if (restart) begin
      state_d = S_XFER;
      fc_d    = '0;
      t_d     = CNT_W'(tfrm);
      clamp_d = (treq < 64'(TMIN));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      fc_q    <= '0;
      t_q     <= '0;
      clamp_q <= 1'b0;
      phi_p_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      expc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
      t_q     <= t_d;
      clamp_q <= clamp_d;
      phi_p_q <= (state_q == S_XFER);
      busy_q  <= (state_q != S_IDLE);
      done_q  <= eof;
      expc_q  <= clamp_q;
    end
  end

  ccd_pixel_phase #(.PIX_DIV(PIX_DIV), .N_PIXELS(N_PIXELS), .PIX_W(PIX_W)) u_phase (
    .clk          (clk),
    .rst          (rst),
    .run_i        (run),
    .phi_l1_o     (bus.phi_l1),
    .phi_l2_o     (bus.phi_l2),
    .phi_r_o      (bus.phi_r),
    .sample_o     (bus.sample),
    .pix_idx_o    (bus.pix_idx),
    .last_pixel_o (last_pix)
  );

  assign bus.phi_p       = phi_p_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = done_q;
  assign bus.exp_clamped = expc_q;
endmodule

// File: tb/tb_ccd_frame_timer.sv
// Bench for ccd_frame_timer: frame-position reference model plus directed and random stimulus.
module tb_ccd_frame_timer;
  localparam int NPIX = 4, PDIV = 8, PL = 2, GD = 2, MINE = 20, TMIN = 36;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ccd_frame_timer_if #(.FSEL_W(8), .PIX_W(2)) b0 ();
  ccd_frame_timer_if #(.FSEL_W(8), .PIX_W(2)) b1 ();

  assign b1.enable      = b0.enable;
  assign b1.single_shot = b0.single_shot;
  assign b1.start       = b0.start;
  assign b1.f_select    = b0.f_select;

  ccd_frame_timer #(.CNT_W(32), .FSEL_W(8), .MIN_EXP(MINE), .EXP_STEP(10), .N_PIXELS(NPIX),
                    .PIX_DIV(PDIV), .PULSE_LEN(PL), .GUARD(GD)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  ccd_frame_timer #(.CNT_W(12), .FSEL_W(8), .MIN_EXP(MINE), .EXP_STEP(20), .N_PIXELS(NPIX),
                    .PIX_DIV(PDIV), .PULSE_LEN(PL), .GUARD(GD)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  int total = 0;
  int bad   = 0;

  // Reference model: per instance, whether a frame runs, position in it and its period.
  bit         mact[2];
  int         mpos[2];
  longint     mper[2];
  bit         mclamp[2];
  logic [7:0] ev[2];
  logic [1:0] epix[2];
  bit         started = 0;
  int         step_of[2] = '{10, 20};
  longint     lim_of[2]  = '{64'hFFFF_FFFF, 4095};

  function automatic logic [7:0] outs(input bit act, input int p, input longint per,
                                      input bit cl, output logic [1:0] pix);
    bit pp, l1, l2, r, s, d, b;
    int rr, ph;
    {pp, l1, l2, r, s, d, b} = '0;
    pix = 2'd0;
    if (act) begin
      pp = (p < PL);
      rr = p - PL - GD;
      if (rr >= 0 && rr < NPIX * PDIV) begin
        ph  = rr % PDIV;
        l2  = (ph < PDIV / 2);
        l1  = !l2;
        r   = (ph < PDIV / 4);
        s   = (ph == 3 * PDIV / 4);
        pix = 2'(rr / PDIV);
      end
      d = (p == per - 1);
      b = 1'b1;
    end
    return {pp, l1, l2, r, s, d, b, cl};
  endfunction

  task automatic latch(input int i);
    longint treq, sat;
    treq      = MINE + longint'(b0.f_select) * step_of[i];
    sat       = (treq > lim_of[i]) ? lim_of[i] : treq;
    mper[i]   = (sat < TMIN) ? TMIN : sat;
    mclamp[i] = (treq < TMIN);
    mpos[i]   = 0;
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mact[i] = 0; mpos[i] = 0; mclamp[i] = 0; ev[i] = '0; epix[i] = '0;
      end else begin
        ev[i] = outs(mact[i], mpos[i], mper[i], mclamp[i], epix[i]);
        if (mact[i]) begin
          if (mpos[i] == mper[i] - 1) begin
            if (b0.enable && !b0.single_shot) latch(i);
            else mact[i] = 0;
          end else mpos[i]++;
        end else if (b0.enable && (!b0.single_shot || b0.start)) begin
          mact[i] = 1;
          latch(i);
        end
      end
    end
    if (rst) started = 1;
  end

  int cyc = 0;
  always @(negedge clk) begin
    logic [7:0] av[2];
    logic [1:0] ap[2];
    cyc++;
    av[0] = {b0.phi_p, b0.phi_l1, b0.phi_l2, b0.phi_r, b0.sample, b0.frame_done, b0.busy, b0.exp_clamped};
    av[1] = {b1.phi_p, b1.phi_l1, b1.phi_l2, b1.phi_r, b1.sample, b1.frame_done, b1.busy, b1.exp_clamped};
    ap[0] = b0.pix_idx;
    ap[1] = b1.pix_idx;
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        total++;
        if (av[i] !== ev[i] || (ev[i][3] && ap[i] !== epix[i])) begin
          bad++;
          $display("FAIL model cyc=%0d inst=%0d got outs=%b pix=%0d want outs=%b pix=%0d",
                   cyc, i, av[i], ap[i], ev[i], epix[i]);
        end
      end
    end
  end

  // Waveform measurements on instance 0 (and busy length of instance 1).
  int n_pp, n_samp, n_done, n_busy, n_busy1, t_rise = -1, t_fall, t_l2, t_done, period;
  logic [7:0] pixseq;
  logic prev_pp = 0, prev_l2 = 0;
  always @(negedge clk) begin
    if (b0.phi_p && !prev_pp) begin
      if (t_rise >= 0) period = cyc - t_rise;
      t_rise = cyc;
    end
    if (!b0.phi_p && prev_pp) t_fall = cyc;
    if (b0.phi_l2 && !prev_l2 && t_l2 < 0) t_l2 = cyc;
    if (b0.phi_p) n_pp++;
    if (b0.sample) begin n_samp++; pixseq = {pixseq[5:0], b0.pix_idx}; end
    if (b0.frame_done) begin n_done++; t_done = cyc; end
    if (b0.busy) n_busy++;
    if (b1.busy) n_busy1++;
    prev_pp = b0.phi_p;
    prev_l2 = b0.phi_l2;
  end

  task automatic clr();
    n_pp = 0; n_samp = 0; n_done = 0; n_busy = 0; n_busy1 = 0;
    t_l2 = -1; period = 0; pixseq = '0;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    b0.start = 1'b1;
    tick();
    b0.start = 1'b0;
  endtask

  task automatic wait_for(input string name, input int which, input int limit);
    int n;
    n = 0;
    while (n < limit && !((which == 0) ? b0.phi_l2 : b0.sample)) begin
      tick();
      n++;
    end
    if (n >= limit) begin
      bad++;
      total++;
      $display("FAIL %s timeout got=%0d want<%0d", name, n, limit);
    end
  endtask

  initial begin
    b0.enable = 0; b0.single_shot = 0; b0.start = 0; b0.f_select = 0;
    clr();
    repeat (3) tick();
    chk("reset outs", {b0.phi_p, b0.phi_l1, b0.phi_l2, b0.phi_r, b0.sample, b0.frame_done,
                       b0.busy, b0.exp_clamped, b1.busy}, 0);
    rst = 0;
    tick();

    // Clamped single shot.
    b0.enable = 1; b0.single_shot = 1; b0.f_select = 0;
    clr();
    pulse_start();
    repeat (45) tick();
    chk("ss phi_p cycles", n_pp, 2);
    chk("ss guard gap", t_l2 - t_fall, 2);
    chk("ss samples", n_samp, 4);
    chk("ss pix seq", pixseq, 8'h1B);
    chk("ss done count", n_done, 1);
    chk("ss busy cycles", n_busy, 36);
    chk("ss rise to done", t_done - t_rise, 35);
    chk("ss clamped", b0.exp_clamped, 1);
    chk("ss idle", b0.busy, 0);

    // Continuous, unclamped.
    b0.single_shot = 0; b0.f_select = 3;
    clr();
    repeat (160) tick();
    chk("cont period", period, 50);
    chk("cont clamped", b0.exp_clamped, 0);
    chk("cont done count", n_done, 3);

    // Mid-frame f_select change and enable drop.
    wait_for("wait readout", 0, 100);
    b0.f_select = 5; b0.enable = 0;
    clr();
    repeat (80) tick();
    chk("stop done count", n_done, 1);
    chk("stop no phi_p", n_pp, 0);
    chk("stop period", t_done - t_rise, 49);
    chk("stop idle", b0.busy, 0);

    // Reset during readout, then a clean frame.
    b0.enable = 1; b0.single_shot = 1; b0.f_select = 0;
    pulse_start();
    wait_for("wait sample", 1, 60);
    rst = 1;
    tick();
    chk("abort outs", {b0.phi_p, b0.phi_l1, b0.phi_l2, b0.phi_r, b0.sample, b0.frame_done,
                       b0.busy, b0.exp_clamped}, 0);
    rst = 0;
    tick();
    clr();
    pulse_start();
    repeat (45) tick();
    chk("rerun samples", n_samp, 4);
    chk("rerun pix seq", pixseq, 8'h1B);
    chk("rerun done count", n_done, 1);

    // Saturation on the 12-bit instance.
    b0.f_select = 8'd255;
    clr();
    pulse_start();
    repeat (4200) tick();
    chk("sat busy cycles", n_busy1, 4095);
    chk("sat clamped", b1.exp_clamped, 0);

    // Random control traffic.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) < 3) b0.enable = ~b0.enable;
      if ($urandom_range(0, 99) < 2) b0.single_shot = ~b0.single_shot;
      b0.start = ($urandom_range(0, 99) < 10);
      if ($urandom_range(0, 99) < 5) b0.f_select = 8'($urandom_range(0, 7));
      rst = ($urandom_range(0, 999) < 5);
      tick();
    end
    rst = 0; b0.start = 0; b0.enable = 0;
    begin
      int n;
      n = 0;
      while (n < 5000 && (b0.busy || b1.busy)) begin tick(); n++; end
      chk("drain idle", {b0.busy, b1.busy}, 0);
    end
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
